// File: rtl/frame_checker_pkg.sv
// frame_checker_pkg
//   Framing constants, FSM states and completion codes for the UART
//   test-frame stream. Shared with the transmit-side streamer so both
//   ends agree on framing.
//   Contents: SOF/EOF defaults, state_t (IDLE/DATA/EOF), err_t codes,
//   16-bit saturating increment helper.
package frame_checker_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'h55;
    localparam logic [7:0] EOF_DEFAULT = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_EOF
    } state_t;

    typedef enum logic [2:0] {
        ERR_OK      = 3'd0,
        ERR_DATA    = 3'd1,
        ERR_EOF     = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_RXERR   = 3'd4
    } err_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_checker_gap_timer.sv
// gap_timer
//   Counts clk cycles since the last clear while enabled; expired is high
//   on the cycle in which the TIMEOUT_CYC-th edge since the clear would
//   occur, so an abort registered on that edge lands exactly TIMEOUT_CYC
//   cycles after the clearing edge.
//   Ports: clk, rst (async, active-high), clear (restart count),
//          enable (count while high, held at zero otherwise),
//          expired (combinational timeout flag).
module gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frame_checker.sv
// frame_checker
//   Receive-side checker for the UART test-frame stream:
//   SOF, PAYLOAD_LEN bytes counting 0,1,2.. (mod 256), EOF.
//   Ports:
//     clk, rst (async, active-high)
//     rx_valid/rx_data/rx_err : one received byte per rx_valid pulse
//     busy                    : frame in progress (DATA or EOF state)
//     frame_done              : 1-cycle pulse when a frame ends or aborts
//     frame_ok/err_code       : status of that frame
//     mismatch_cnt/first_bad_idx : payload error summary of last frame
//     good_frames/bad_frames  : saturating statistics
module frame_checker
    import frame_checker_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT,
    parameter logic [7:0]  EOF_BYTE    = EOF_DEFAULT,
    parameter int unsigned PAYLOAD_LEN = 256,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_err,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [2:0]       err_code,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      first_bad_idx,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames
);

    localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_LEN - 1);

    state_t           state, state_n;
    logic [15:0]      idx, idx_n;
    logic [15:0]      mm, mm_n;
    logic [15:0]      first, first_n;

    logic             done_n, ok_n;
    logic [2:0]       err_n;
    logic [15:0]      mmo_n, fbo_n;
    logic [CNT_W-1:0] good_n, bad_n;

    logic             finish;
    err_t             fin_err;
    logic             expired;

    assign busy = (state != ST_IDLE);

    // Any accepted byte restarts the inter-byte gap count.
    gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (busy),
        .expired(expired)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        mm_n    = mm;
        first_n = first;
        done_n  = 1'b0;
        ok_n    = frame_ok;
        err_n   = err_code;
        mmo_n   = mismatch_cnt;
        fbo_n   = first_bad_idx;
        good_n  = good_frames;
        bad_n   = bad_frames;
        finish  = 1'b0;
        fin_err = ERR_OK;

        case (state)
            ST_IDLE: begin
                // Hunt mode: everything but SOF (including rx_err) is dropped.
                if (rx_valid && !rx_err && rx_data == SOF_BYTE) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                    mm_n    = '0;
                    first_n = '1;
                end
            end
            ST_DATA, ST_EOF: begin
                // Priority: rx_err > rx_valid > gap timeout.
                if (rx_err) begin
                    finish  = 1'b1;
                    fin_err = ERR_RXERR;
                end else if (rx_valid) begin
                    if (state == ST_DATA) begin
                        if (rx_data != idx[7:0]) begin
                            mm_n = sat_inc16(mm);
                            if (first == 16'hFFFF) begin
                                first_n = idx;
                            end
                        end
                        idx_n = idx + 16'd1;
                        if (idx == LAST_IDX) begin
                            state_n = ST_EOF;
                        end
                    end else begin
                        finish = 1'b1;
                        if (rx_data != EOF_BYTE) begin
                            fin_err = ERR_EOF;
                        end else if (mm != 16'd0) begin
                            fin_err = ERR_DATA;
                        end else begin
                            fin_err = ERR_OK;
                        end
                    end
                end else if (expired) begin
                    finish  = 1'b1;
                    fin_err = ERR_TIMEOUT;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (finish) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            ok_n    = (fin_err == ERR_OK);
            err_n   = fin_err;
            mmo_n   = mm;
            fbo_n   = first;
            if (fin_err == ERR_OK) begin
                if (good_frames != '1) good_n = good_frames + 1'b1;
            end else begin
                if (bad_frames != '1) bad_n = bad_frames + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            mm            <= '0;
            first         <= '0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_code      <= '0;
            mismatch_cnt  <= '0;
            first_bad_idx <= '1;
            good_frames   <= '0;
            bad_frames    <= '0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            mm            <= mm_n;
            first         <= first_n;
            frame_done    <= done_n;
            frame_ok      <= ok_n;
            err_code      <= err_n;
            mismatch_cnt  <= mmo_n;
            first_bad_idx <= fbo_n;
            good_frames   <= good_n;
            bad_frames    <= bad_n;
        end
    end

endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker
//   Directed plus randomized frames against a frame-level reference model:
//   expected status is derived from the payload array, the end-of-frame
//   event and the counting-sequence rule.
module tb_frame_checker;

    localparam int PLEN  = 256;
    localparam int TOUT  = 1000;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    // end-of-frame kinds
    localparam int K_EOF   = 0;
    localparam int K_TOUT  = 1;
    localparam int K_RXERR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_err;
    logic          busy;
    logic          frame_done;
    logic          frame_ok;
    logic [2:0]    err_code;
    logic [15:0]   mismatch_cnt;
    logic [15:0]   first_bad_idx;
    logic [CW-1:0] good_frames;
    logic [CW-1:0] bad_frames;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_good = 0;
    int exp_bad  = 0;
    int spurious = 0;
    logic [7:0] pay [PLEN];

    always #5 clk = ~clk;

    frame_checker #(
        .SOF_BYTE   (8'h55),
        .EOF_BYTE   (8'hAA),
        .PAYLOAD_LEN(PLEN),
        .TIMEOUT_CYC(TOUT),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_err       (rx_err),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .err_code     (err_code),
        .mismatch_cnt (mismatch_cnt),
        .first_bad_idx(first_bad_idx),
        .good_frames  (good_frames),
        .bad_frames   (bad_frames)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; returns on the negedge after the consuming posedge.
    task automatic drive_byte(input logic [7:0] b, input logic e);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_err   = e;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (frame_done) spurious++;
        end
    endtask

    task automatic fill_clean();
        for (int i = 0; i < PLEN; i++) pay[i] = 8'(i);
    endtask

    // Reference: outcome of a frame from its payload and how it ended.
    task automatic model(input int kind, input int stop, input logic [7:0] eofb,
                         output int err, output int mm, output int first);
        int sent;
        sent  = (kind == K_EOF) ? PLEN : stop;
        mm    = 0;
        first = 16'hFFFF;
        for (int i = 0; i < sent; i++) begin
            if (pay[i] != 8'(i % 256)) begin
                if (mm < 16'hFFFF) mm++;
                if (first == 16'hFFFF) first = i;
            end
        end
        if (kind == K_TOUT)       err = 3;
        else if (kind == K_RXERR) err = 4;
        else if (eofb != 8'hAA)   err = 2;
        else                      err = (mm != 0) ? 1 : 0;
        if (err == 0) begin
            if (exp_good < CMAX) exp_good++;
        end else begin
            if (exp_bad < CMAX) exp_bad++;
        end
    endtask

    task automatic run_frame(input string tag, input int kind, input int stop,
                             input logic [7:0] eofb, input int maxgap);
        int nsend, cyc, e_err, e_mm, e_first;
        logic [15:0] held_mm;
        spurious = 0;
        nsend = (kind == K_EOF) ? PLEN : stop;
        drive_byte(8'h55, 1'b0);
        if (frame_done) spurious++;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < nsend; i++) begin
            idle($urandom_range(maxgap, 0));
            drive_byte(pay[i], 1'b0);
            if (frame_done) spurious++;
        end
        if (kind == K_EOF) begin
            idle($urandom_range(maxgap, 0));
            drive_byte(eofb, 1'b0);
        end else if (kind == K_RXERR) begin
            idle($urandom_range(maxgap, 0));
            drive_byte(pay[stop], 1'b1);
        end else begin
            cyc = 0;
            while (!frame_done && cyc < TOUT + 100) begin
                @(negedge clk);
                cyc++;
            end
            chk({tag, "_gap"}, 32'(cyc), 32'(TOUT));
        end
        chk({tag, "_early"}, 32'(spurious), 32'd0);
        model(kind, stop, eofb, e_err, e_mm, e_first);
        chk({tag, "_done"},  32'(frame_done),    32'd1);
        chk({tag, "_ok"},    32'(frame_ok),      32'(e_err == 0));
        chk({tag, "_err"},   32'(err_code),      32'(e_err));
        chk({tag, "_mm"},    32'(mismatch_cnt),  32'(e_mm));
        chk({tag, "_first"}, 32'(first_bad_idx), 32'(e_first));
        chk({tag, "_good"},  32'(good_frames),   32'(exp_good));
        chk({tag, "_bad"},   32'(bad_frames),    32'(exp_bad));
        chk({tag, "_idle"},  32'(busy),          32'd0);
        held_mm = 16'(e_mm);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(frame_done),    32'd0);
        chk({tag, "_hold"},  32'(mismatch_cnt),  32'(held_mm));
    endtask

    initial begin
        int kind, stop;
        logic [7:0] eofb;

        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_err   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(frame_done),    32'd0);
        chk("rst_ok",    32'(frame_ok),      32'd0);
        chk("rst_err",   32'(err_code),      32'd0);
        chk("rst_mm",    32'(mismatch_cnt),  32'd0);
        chk("rst_first", 32'(first_bad_idx), 32'hFFFF);
        chk("rst_good",  32'(good_frames),   32'd0);
        chk("rst_bad",   32'(bad_frames),    32'd0);
        rst = 1'b0;
        idle(2);

        // clean frame
        fill_clean();
        run_frame("clean", K_EOF, 0, 8'hAA, 2);

        // two payload errors
        fill_clean();
        pay[10]  = 8'h0B;
        pay[200] = 8'h00;
        run_frame("data", K_EOF, 0, 8'hAA, 1);

        // wrong EOF that looks like SOF, then a clean frame must pass
        fill_clean();
        run_frame("eof55", K_EOF, 0, 8'h55, 1);
        run_frame("resync", K_EOF, 0, 8'hAA, 1);

        // stall after payload byte 50
        fill_clean();
        pay[3] = 8'hFF;
        run_frame("tout", K_TOUT, 51, 8'hAA, 1);

        // junk in hunt mode: no frame activity, counters unchanged
        spurious = 0;
        drive_byte(8'h00, 1'b0); if (frame_done || busy) spurious++;
        drive_byte(8'hAA, 1'b0); if (frame_done || busy) spurious++;
        drive_byte(8'hFF, 1'b0); if (frame_done || busy) spurious++;
        rx_err = 1'b1; @(negedge clk); rx_err = 1'b0;
        if (frame_done || busy) spurious++;
        drive_byte(8'h00, 1'b1); if (frame_done || busy) spurious++;
        idle(2);
        chk("junk_quiet", 32'(spurious), 32'd0);
        chk("junk_bad", 32'(bad_frames), 32'(exp_bad));
        fill_clean();
        run_frame("postjunk", K_EOF, 0, 8'hAA, 1);

        // rx_err coincident with payload byte 7
        fill_clean();
        run_frame("rxerr", K_RXERR, 7, 8'hAA, 1);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            fill_clean();
            for (int i = 0; i < PLEN; i++) begin
                if ($urandom_range(63, 0) == 0) pay[i] = pay[i] ^ 8'($urandom_range(255, 1));
            end
            kind = ($urandom_range(3, 0) == 0) ? K_RXERR : K_EOF;
            stop = $urandom_range(PLEN - 1, 0);
            eofb = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'hAA;
            run_frame("rand", kind, stop, eofb, 3);
        end

        // async reset mid-payload, between clock edges
        fill_clean();
        drive_byte(8'h55, 1'b0);
        for (int i = 0; i < 20; i++) drive_byte(pay[i], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",  32'(busy),          32'd0);
        chk("arst_good",  32'(good_frames),   32'd0);
        chk("arst_bad",   32'(bad_frames),    32'd0);
        chk("arst_first", 32'(first_bad_idx), 32'hFFFF);
        chk("arst_err",   32'(err_code),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        idle(1);

        // good_frames saturates at 3 with CNT_W=2
        for (int f = 0; f < 4; f++) begin
            fill_clean();
            run_frame("sat", K_EOF, 0, 8'hAA, 0);
        end
        chk("sat_final", 32'(good_frames), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
